// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
package ps2_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DATA   = 2'd1,
      ST_PARITY = 2'd2,
      ST_STOP   = 2'd3
   } ps2_state_e;

   // Frame FSM state and decoder flags, exposed for observation.
   typedef struct packed {
      ps2_state_e state;
      logic       brk;
      logic       ext;
      logic       shift;
   } ps2_dbg_t;

   localparam logic [7:0] SC_BREAK  = 8'hF0;
   localparam logic [7:0] SC_EXT    = 8'hE0;
   localparam logic [7:0] SC_LSHIFT = 8'h12;
   localparam logic [7:0] SC_RSHIFT = 8'h59;
   localparam logic [7:0] SC_ENTER  = 8'h5A;
   localparam logic [7:0] ASCII_CR  = 8'h0D;

endpackage

// File: rtl/ps2_keyboard_rx_if.sv
// Character output bundle from the keyboard receiver to the text display.
// Handshake: write_en is a one-cycle strobe qualifying data; there is no
// ready, the consumer must take every strobe. frame_err is an independent
// one-cycle strobe. data holds its value between strobes.
interface ps2_keyboard_rx_if;
   logic [7:0] data;
   logic       write_en;
   logic       frame_err;

   modport master (output data, output write_en, output frame_err);
   modport slave  (input  data, input  write_en, input  frame_err);
endinterface

// File: rtl/scancode_to_ascii.sv
// Combinational set-2 scancode to ASCII lookup; returns 8'h00 when unmapped.
module scancode_to_ascii
   import ps2_pkg::*;
(
   input  logic [7:0] scancode,
   input  logic       shift,
   output logic [7:0] ascii
);

   logic [7:0] lo;
   logic [7:0] hi;

   always_comb begin
      lo = 8'h00;
      hi = 8'h00;
      case (scancode)
         8'h1C: lo = "a";  8'h32: lo = "b";  8'h21: lo = "c";  8'h23: lo = "d";
         8'h24: lo = "e";  8'h2B: lo = "f";  8'h34: lo = "g";  8'h33: lo = "h";
         8'h43: lo = "i";  8'h3B: lo = "j";  8'h42: lo = "k";  8'h4B: lo = "l";
         8'h3A: lo = "m";  8'h31: lo = "n";  8'h44: lo = "o";  8'h4D: lo = "p";
         8'h15: lo = "q";  8'h2D: lo = "r";  8'h1B: lo = "s";  8'h2C: lo = "t";
         8'h3C: lo = "u";  8'h2A: lo = "v";  8'h1D: lo = "w";  8'h22: lo = "x";
         8'h35: lo = "y";  8'h1A: lo = "z";
         8'h45: begin lo = "0"; hi = ")"; end
         8'h16: begin lo = "1"; hi = "!"; end
         8'h1E: begin lo = "2"; hi = "@"; end
         8'h26: begin lo = "3"; hi = "#"; end
         8'h25: begin lo = "4"; hi = "$"; end
         8'h2E: begin lo = "5"; hi = "%"; end
         8'h36: begin lo = "6"; hi = "^"; end
         8'h3D: begin lo = "7"; hi = "&"; end
         8'h3E: begin lo = "8"; hi = "*"; end
         8'h46: begin lo = "9"; hi = "("; end
         8'h29: begin lo = 8'h20; hi = 8'h20; end
         SC_ENTER: begin lo = ASCII_CR; hi = ASCII_CR; end
         8'h66: begin lo = 8'h08; hi = 8'h08; end
         default: begin lo = 8'h00; hi = 8'h00; end
      endcase
      // Letters shift by clearing bit 5; other shifted values come from the table.
      if (lo >= "a" && lo <= "z") hi = lo - 8'h20;
      ascii = shift ? hi : lo;
   end

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 set-2 keyboard receiver: frame capture, timeout, make/break/shift
// tracking and ASCII output. Optional macro PS2_PARITY_CHECK_EN enforces odd parity.
module ps2_keyboard_rx
   import ps2_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 2500
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ps2_clk,
   input  logic              ps2_data,
   ps2_keyboard_rx_if.master kbd,
   output ps2_dbg_t          dbg
);

   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES);

   logic clk_s1, clk_s2, clk_s3;
   logic dat_s1, dat_s2;
   logic fall;

   ps2_state_e     state, state_next;
   logic [2:0]     bit_cnt;
   logic [7:0]     shreg;
   logic           par_bit;
   logic [TO_W-1:0] to_cnt;
   logic           timeout_hit;
   logic           parity_ok;
   logic           accept;
   logic           reject;

   logic [7:0] byte_q;
   logic       byte_vld;
   logic       frame_err_q;

   logic       brk, ext, shift;
   logic [7:0] data_q;
   logic       write_en_q;
   logic [7:0] ascii;

   // Pins idle high, so the synchronizers reset to 1 to avoid a false edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         clk_s1 <= 1'b1; clk_s2 <= 1'b1; clk_s3 <= 1'b1;
         dat_s1 <= 1'b1; dat_s2 <= 1'b1;
      end else begin
         clk_s1 <= ps2_clk; clk_s2 <= clk_s1; clk_s3 <= clk_s2;
         dat_s1 <= ps2_data; dat_s2 <= dat_s1;
      end
   end

   assign fall = clk_s3 & ~clk_s2;

`ifdef PS2_PARITY_CHECK_EN
   assign parity_ok = ^{shreg, par_bit};
`else
   logic par_unused;
   assign par_unused = par_bit;
   assign parity_ok  = 1'b1;
`endif

   assign timeout_hit = (state != ST_IDLE) && (to_cnt == TO_LIMIT);

   always_comb begin
      state_next = state;
      accept     = 1'b0;
      reject     = 1'b0;
      case (state)
         ST_IDLE:   if (fall && !dat_s2) state_next = ST_DATA;
         ST_DATA:   if (fall && bit_cnt == 3'd7) state_next = ST_PARITY;
         ST_PARITY: if (fall) state_next = ST_STOP;
         ST_STOP: begin
            if (fall) begin
               state_next = ST_IDLE;
               accept     = dat_s2 & parity_ok;
               reject     = ~(dat_s2 & parity_ok);
            end
         end
         default: state_next = ST_IDLE;
      endcase
      if (timeout_hit) begin
         state_next = ST_IDLE;
         accept     = 1'b0;
         reject     = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= ST_IDLE;
         bit_cnt     <= 3'd0;
         shreg       <= 8'h00;
         par_bit     <= 1'b0;
         to_cnt      <= '0;
         byte_q      <= 8'h00;
         byte_vld    <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state <= state_next;
         if (fall && state == ST_IDLE) bit_cnt <= 3'd0;
         if (fall && state == ST_DATA) begin
            shreg   <= {dat_s2, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
         end
         if (fall && state == ST_PARITY) par_bit <= dat_s2;
         if (state == ST_IDLE || fall || timeout_hit) to_cnt <= '0;
         else                                         to_cnt <= to_cnt + 1'b1;
         byte_vld    <= accept;
         if (accept) byte_q <= shreg;
         frame_err_q <= reject | timeout_hit;
      end
   end

   scancode_to_ascii u_lut (
      .scancode (byte_q),
      .shift    (shift),
      .ascii    (ascii)
   );

   // Prefix codes only arm flags; the following code consumes them silently.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         brk        <= 1'b0;
         ext        <= 1'b0;
         shift      <= 1'b0;
         data_q     <= 8'h00;
         write_en_q <= 1'b0;
      end else begin
         write_en_q <= 1'b0;
         if (byte_vld) begin
            if (byte_q == SC_BREAK) begin
               brk <= 1'b1;
            end else if (byte_q == SC_EXT) begin
               ext <= 1'b1;
            end else if (byte_q == SC_LSHIFT || byte_q == SC_RSHIFT) begin
               shift <= ~brk;
               brk   <= 1'b0;
               ext   <= 1'b0;
            end else if (brk || ext) begin
               brk <= 1'b0;
               ext <= 1'b0;
            end else if (ascii != 8'h00) begin
               data_q     <= ascii;
               write_en_q <= 1'b1;
            end
         end
      end
   end

   assign kbd.data      = data_q;
   assign kbd.write_en  = write_en_q;
   assign kbd.frame_err = frame_err_q;

   assign dbg.state = state;
   assign dbg.brk   = brk;
   assign dbg.ext   = ext;
   assign dbg.shift = shift;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Bench for ps2_keyboard_rx: directed scenarios plus a randomized scancode
// stream checked against a table-driven keyboard model.
module tb_ps2_keyboard_rx;
   import ps2_pkg::*;

   localparam int TO   = 2500;
   localparam int HALF = 20;

   logic     clk      = 1'b0;
   logic     reset    = 1'b0;
   logic     ps2_clk  = 1'b1;
   logic     ps2_data = 1'b1;
   ps2_dbg_t dbg;

   ps2_keyboard_rx_if kbd();

   ps2_keyboard_rx #(.TIMEOUT_CYCLES(TO)) dut (
      .clk      (clk),
      .reset    (reset),
      .ps2_clk  (ps2_clk),
      .ps2_data (ps2_data),
      .kbd      (kbd),
      .dbg      (dbg)
   );

   always #5 clk = ~clk;

   int  n_vec   = 0;
   int  n_err   = 0;
   int  err_cnt = 0;
   int  we_lat;
   int  err_lat;
   bit  we_prev   = 1'b0;
   bit  we_double = 1'b0;
   logic [7:0] exp_q[$];
   logic [7:0] got_q[$];

   bit m_brk, m_ext, m_shift;
   string lower_s = "abcdefghijklmnopqrstuvwxyz";
   string digit_s = "0123456789";
   string sym_s   = ")!@#$%^&*(";
   logic [7:0] letter_sc [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
                                  8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31,
                                  8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C,
                                  8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
   logic [7:0] digit_sc [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
                                 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
   logic [7:0] special_sc [3] = '{8'h29, 8'h5A, 8'h66};

   // Output monitor: collects characters and error strobes while out of reset.
   initial forever begin
      @(negedge clk);
      if (reset) begin
         if (kbd.write_en) got_q.push_back(kbd.data);
         if (kbd.frame_err) err_cnt++;
         if (kbd.write_en && we_prev) we_double = 1'b1;
         we_prev = kbd.write_en;
      end else begin
         we_prev = 1'b0;
      end
   end

   function automatic logic [7:0] lookup(input logic [7:0] code, input bit sh);
      logic [7:0] r;
      r = 8'h00;
      for (int i = 0; i < 26; i++)
         if (letter_sc[i] == code) r = sh ? 8'(lower_s[i]) - 8'h20 : 8'(lower_s[i]);
      for (int i = 0; i < 10; i++)
         if (digit_sc[i] == code) r = sh ? 8'(sym_s[i]) : 8'(digit_s[i]);
      if (code == 8'h29) r = 8'h20;
      if (code == 8'h5A) r = 8'h0D;
      if (code == 8'h66) r = 8'h08;
      return r;
   endfunction

   task automatic model_byte(input logic [7:0] code);
      logic [7:0] a;
      if (code == 8'hF0) m_brk = 1'b1;
      else if (code == 8'hE0) m_ext = 1'b1;
      else if (code == 8'h12 || code == 8'h59) begin
         m_shift = !m_brk; m_brk = 1'b0; m_ext = 1'b0;
      end else if (m_brk || m_ext) begin
         m_brk = 1'b0; m_ext = 1'b0;
      end else begin
         a = lookup(code, m_shift);
         if (a != 8'h00) exp_q.push_back(a);
      end
   endtask

   task automatic send_bit(input logic b);
      ps2_data = b;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
   endtask

   // Full frame; latencies of write_en / frame_err are measured from the stop-bit edge.
   task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
      logic [9:0] f;
      f = {(~^b) ^ bad_par, b, 1'b0};
      for (int i = 0; i < 10; i++) send_bit(f[i]);
      ps2_data = ~bad_stop;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      we_lat  = -1;
      err_lat = -1;
      for (int k = 1; k <= HALF; k++) begin
         @(negedge clk);
         if (kbd.write_en && we_lat < 0) we_lat = k;
         if (kbd.frame_err && err_lat < 0) err_lat = k;
      end
      ps2_clk  = 1'b1;
      ps2_data = 1'b1;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      n_vec++; if (kbd.data !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h want 00", kbd.data); end
      n_vec++; if (kbd.write_en !== 1'b0) begin n_err++; $display("FAIL reset_we: got %b want 0", kbd.write_en); end
      n_vec++; if (kbd.frame_err !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b want 0", kbd.frame_err); end
      n_vec++; if (dbg.state !== ST_IDLE) begin n_err++; $display("FAIL reset_state: got %0d want IDLE", dbg.state); end
      reset = 1'b1;
      repeat (5) @(negedge clk);
   endtask

   task automatic test_single();
      got_q.delete();
      send_frame(8'h1C, 1'b0, 1'b0);
      repeat (10) @(negedge clk);
      n_vec++; if (got_q.size() != 1 || got_q[0] !== 8'h61) begin
         n_err++; $display("FAIL single_a: got %0d chars first %h want 1 char 61", got_q.size(), got_q.size() ? got_q[0] : 8'h00);
      end
      // Pin-to-fall is 2-3 cycles depending on phase, then two pipeline stages.
      n_vec++; if (we_lat < 3 || we_lat > 5) begin n_err++; $display("FAIL single_latency: got %0d want 3..5", we_lat); end
   endtask

   task automatic test_shift();
      logic [7:0] seq [7] = '{8'h12, 8'h1C, 8'hF0, 8'h1C, 8'hF0, 8'h12, 8'h1C};
      got_q.delete();
      exp_q = '{8'h41, 8'h61};
      for (int i = 0; i < 7; i++) send_frame(seq[i], 1'b0, 1'b0);
      repeat (10) @(negedge clk);
      n_vec++; if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL shift_count: got %0d want %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         n_vec++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL shift_char%0d: got %h want %h", i, got_q[i], exp_q[i]); end
      end
      n_vec++; if (dbg.shift !== 1'b0) begin n_err++; $display("FAIL shift_release: got %b want 0", dbg.shift); end
   endtask

   task automatic test_special();
      got_q.delete();
      exp_q = '{8'h0D, 8'h61};
      send_frame(8'h5A, 1'b0, 1'b0);
      send_frame(8'hE0, 1'b0, 1'b0);
      send_frame(8'h75, 1'b0, 1'b0);
      repeat (10) @(negedge clk);
      n_vec++; if (dbg.brk !== 1'b0 || dbg.ext !== 1'b0) begin
         n_err++; $display("FAIL ext_flags: got brk=%b ext=%b want 0 0", dbg.brk, dbg.ext);
      end
      send_frame(8'h1C, 1'b0, 1'b0);
      repeat (10) @(negedge clk);
      n_vec++; if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL special_count: got %0d want %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         n_vec++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL special_char%0d: got %h want %h", i, got_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_parity();
      int e0;
      got_q.delete();
      e0 = err_cnt;
      send_frame(8'h1C, 1'b1, 1'b0);
      repeat (10) @(negedge clk);
`ifdef PS2_PARITY_CHECK_EN
      n_vec++; if (err_cnt - e0 != 1) begin n_err++; $display("FAIL parity_err: got %0d pulses want 1", err_cnt - e0); end
      n_vec++; if (got_q.size() != 0) begin n_err++; $display("FAIL parity_drop: got %0d chars want 0", got_q.size()); end
      n_vec++; if (err_lat < 2 || err_lat > 4) begin n_err++; $display("FAIL parity_latency: got %0d want 2..4", err_lat); end
`else
      n_vec++; if (err_cnt - e0 != 0) begin n_err++; $display("FAIL parity_ignored_err: got %0d pulses want 0", err_cnt - e0); end
      n_vec++; if (got_q.size() != 1 || got_q[0] !== 8'h61) begin
         n_err++; $display("FAIL parity_ignored_char: got %0d chars want 1 char 61", got_q.size());
      end
`endif
      e0 = err_cnt;
      send_frame(8'h1C, 1'b0, 1'b1);
      repeat (10) @(negedge clk);
      n_vec++; if (err_cnt - e0 != 1) begin n_err++; $display("FAIL stop_err: got %0d pulses want 1", err_cnt - e0); end
   endtask

   task automatic test_timeout();
      int e0;
      got_q.delete();
      e0 = err_cnt;
      send_bit(1'b0);
      send_bit(1'b0); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
      repeat (TO + 10) @(negedge clk);
      n_vec++; if (err_cnt - e0 != 1) begin n_err++; $display("FAIL timeout_err: got %0d pulses want 1", err_cnt - e0); end
      n_vec++; if (dbg.state !== ST_IDLE) begin n_err++; $display("FAIL timeout_state: got %0d want IDLE", dbg.state); end
      send_frame(8'h29, 1'b0, 1'b0);
      repeat (10) @(negedge clk);
      n_vec++; if (got_q.size() != 1 || got_q[0] !== 8'h20) begin
         n_err++; $display("FAIL timeout_recover: got %0d chars first %h want 1 char 20", got_q.size(), got_q.size() ? got_q[0] : 8'h00);
      end
   endtask

   task automatic test_reset_mid();
      got_q.delete();
      send_bit(1'b0);
      send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      n_vec++; if (kbd.data !== 8'h00 || kbd.write_en !== 1'b0 || kbd.frame_err !== 1'b0) begin
         n_err++; $display("FAIL midreset_out: got %h/%b/%b want 00/0/0", kbd.data, kbd.write_en, kbd.frame_err);
      end
      n_vec++; if (dbg.state !== ST_IDLE) begin n_err++; $display("FAIL midreset_state: got %0d want IDLE", dbg.state); end
      repeat (3) @(negedge clk);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      send_frame(8'h16, 1'b0, 1'b0);
      repeat (10) @(negedge clk);
      n_vec++; if (got_q.size() != 1 || got_q[0] !== 8'h31) begin
         n_err++; $display("FAIL midreset_next: got %0d chars first %h want 1 char 31", got_q.size(), got_q.size() ? got_q[0] : 8'h00);
      end
   endtask

   task automatic test_random();
      int e0, exp_err, sel, kind;
      bit bad;
      logic [7:0] code;
      m_brk = 1'b0; m_ext = 1'b0; m_shift = 1'b0;
      got_q.delete(); exp_q.delete();
      e0 = err_cnt; exp_err = 0;
      for (int n = 0; n < 40; n++) begin
         sel = $urandom_range(0, 9);
         case (sel)
            0, 1, 2: code = letter_sc[$urandom_range(0, 25)];
            3:       code = digit_sc[$urandom_range(0, 9)];
            4:       code = $urandom_range(0, 1) ? 8'h12 : 8'h59;
            5:       code = 8'hF0;
            6:       code = 8'hE0;
            7:       code = special_sc[$urandom_range(0, 2)];
            default: code = 8'($urandom);
         endcase
         bad  = ($urandom_range(0, 7) == 0);
         kind = $urandom_range(0, 1);
         send_frame(code, bad && kind == 0, bad && kind == 1);
         if (bad && kind == 1) exp_err++;
`ifdef PS2_PARITY_CHECK_EN
         else if (bad) exp_err++;
`endif
         else model_byte(code);
      end
      repeat (10) @(negedge clk);
      n_vec++; if (err_cnt - e0 != exp_err) begin n_err++; $display("FAIL random_errs: got %0d want %0d", err_cnt - e0, exp_err); end
      n_vec++; if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL random_count: got %0d want %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         n_vec++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL random_char%0d: got %h want %h", i, got_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_back_to_back();
      n_vec++; if (we_double) begin n_err++; $display("FAIL we_spacing: got back-to-back write_en want isolated pulses"); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_shift();
      test_special();
      test_parity();
      test_timeout();
      test_reset_mid();
      test_random();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
